picture_scanner: RTL and testbench

// - Downstream consumer of the memory picture read port; runs on the picture clock domain.
// - On a frame request, walks the 16x16 picture region row-major (left-to-right, top-to-bottom).

---
 rtl/picture_pkg.sv | 11 +
 rtl/pixel_fifo.sv | 34 +++
 rtl/picture_scanner.sv | 79 +++++++
 tb/tb_picture_scanner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/picture_pkg.sv
// picture_pkg: shared geometry, widths and scanner state encoding for the picture read path.
package picture_pkg;
  localparam int PIC_BASE_ADRS = 1792;
  localparam int PIC_W = 16;
  localparam int PIC_H = 16;
  localparam int PIX_W = 24;
  localparam int ADRS_W = 11;
  localparam int FIFO_DEPTH = 2;
  localparam int NPIX = PIC_W * PIC_H;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} scan_state_e;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: small synchronous FIFO with occupancy count; push and pop may coincide when full.
module pixel_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push_i ? wr_q + AW'(1) : wr_q;
      rd_q <= pop_i ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/picture_scanner.sv
// picture_scanner: walks the picture region row-major on request and streams pixels with
// sof/eol/eof flags, throttling reads so the output buffer can never overflow.
module picture_scanner
  import picture_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic [ADRS_W-1:0] picture_radrs,
  input  logic [PIX_W-1:0]  picture_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              frame_done
);
  localparam int IW = $clog2(NPIX);
  localparam int CW = $clog2(PIC_W);
  localparam int RW = $clog2(PIC_H);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  scan_state_e state_q, state_d;
  logic [IW-1:0] rd_idx_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic inflight_q, frame_done_q;
  logic [OW-1:0] occ;
  logic start, issue, pop, last_pop;
  assign pop = pix_valid && pix_ready;
  assign pix_valid = occ != '0;
  // the frame_done cycle still counts as busy for request acceptance
  assign start = frame_start && state_q == IDLE && !frame_done_q;
  assign issue = state_q == FETCH &&
                 ({1'b0, occ} + (OW+1)'(inflight_q) - (OW+1)'(pop)) < (OW+1)'(FIFO_DEPTH);
  assign pix_eol = col_q == CW'(PIC_W - 1);
  assign pix_sof = col_q == '0 && row_q == '0;
  assign pix_eof = pix_eol && row_q == RW'(PIC_H - 1);
  assign last_pop = pop && pix_eof;
  assign picture_radrs = ADRS_W'(PIC_BASE_ADRS) + ADRS_W'(rd_idx_q);
  assign frame_done = frame_done_q;
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && start) ? FETCH :
              (state_q == FETCH && issue && rd_idx_q == IW'(NPIX - 1)) ? DRAIN :
              (state_q == DRAIN && last_pop) ? IDLE : state_q;
  end
  always_comb begin
    busy = state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idx_q <= '0;
      inflight_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rd_idx_q <= start ? '0 : issue ? rd_idx_q + IW'(1) : rd_idx_q;
      inflight_q <= issue;
      col_q <= start ? '0 : pop ? col_q + CW'(1) : col_q;
      row_q <= start ? '0 : (pop && pix_eol) ? row_q + RW'(1) : row_q;
      frame_done_q <= last_pop;
    end
  end
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (inflight_q),
    .din_i  (picture_data),
    .pop_i  (pop),
    .dout_o (pix_data),
    .count_o(occ)
  );
endmodule

// File: tb/tb_picture_scanner.sv
// tb_picture_scanner: directed bench with a registered-read memory model holding mem[1792+i]=i.
module tb_picture_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic pix_ready = 1'b0;
  logic [10:0] picture_radrs;
  logic [23:0] picture_data = '0;
  logic [23:0] pix_data;
  logic pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done;
  logic [23:0] mem [2048];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) picture_data <= mem[picture_radrs];

  picture_scanner dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .picture_radrs(picture_radrs),
    .picture_data (picture_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol),
    .pix_eof      (pix_eof),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // leaves the bench at t0+3, where the first pixel must be valid
  task automatic start_frame;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid_t1", 32'(pix_valid), 32'd0);
    chk("start_adrs_t1", 32'(picture_radrs), 32'd1792);
    step;
    chk("start_valid_t2", 32'(pix_valid), 32'd0);
    chk("start_adrs_t2", 32'(picture_radrs), 32'd1793);
    step;
    chk("start_valid_t3", 32'(pix_valid), 32'd1);
  endtask

  task automatic collect(input int n, input bit toggle, input int fs_at);
    int got = 0;
    int cyc = 0;
    int dones = 0;
    logic [26:0] held = '0;
    bit stalled = 1'b0;
    bit fired = 1'b0;
    bit bad = 1'b0;
    while (got < n && cyc < 4000) begin
      pix_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      frame_start = (got == fs_at) && !fired;
      if (frame_start) begin
        fired = 1'b1;
        chk("busy_at_restart", 32'(busy), 32'd1);
      end
      if (stalled) chk("stall_stable", 32'({pix_sof, pix_eol, pix_eof, pix_data}), 32'(held));
      if (picture_radrs < 11'd1792) bad = 1'b1;
      if (frame_done) dones++;
      if (pix_valid && pix_ready) begin
        chk("pix_data", 32'(pix_data), 32'(got % 256));
        chk("pix_sof", 32'(pix_sof), 32'(got % 256 == 0));
        chk("pix_eol", 32'(pix_eol), 32'(got % 16 == 15));
        chk("pix_eof", 32'(pix_eof), 32'(got % 256 == 255));
        got++;
      end
      stalled = pix_valid && !pix_ready;
      held = {pix_sof, pix_eol, pix_eof, pix_data};
      step;
      cyc++;
    end
    frame_start = 1'b0;
    chk("pix_count", 32'(got), 32'(n));
    if (!toggle) chk("throughput_cycles", 32'(cyc), 32'(n));
    chk("adrs_range", 32'(bad), 32'd0);
    chk("no_early_done", 32'(dones), 32'd0);
  endtask

  task automatic end_frame(input bit fs);
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("done_valid", 32'(pix_valid), 32'd0);
    frame_start = fs;
    step;
    frame_start = 1'b0;
    chk("done_clear", 32'(frame_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = (i >= 1792) ? 24'(i - 1792) : 24'd0;
    step;
    step;
    chk("rst_adrs", 32'(picture_radrs), 32'd1792);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    pix_ready = 1'b1;
    step;
    chk("idle_valid", 32'(pix_valid), 32'd0);
    chk("idle_adrs", 32'(picture_radrs), 32'd1792);
    // full-rate frame
    start_frame;
    collect(256, 1'b0, -1);
    end_frame(1'b0);
    // alternating ready
    start_frame;
    collect(256, 1'b1, -1);
    end_frame(1'b0);
    // stalled consumer: two reads issued, then address holds with a full buffer
    pix_ready = 1'b0;
    start_frame;
    for (int i = 0; i < 17; i++) begin
      chk("stall_adrs", 32'(picture_radrs), 32'd1794);
      chk("stall_data", 32'(pix_data), 32'd0);
      chk("stall_valid", 32'(pix_valid), 32'd1);
      step;
    end
    collect(256, 1'b0, -1);
    end_frame(1'b0);
    // frame_start mid-frame is ignored
    start_frame;
    collect(256, 1'b0, 100);
    end_frame(1'b0);
    // new frame, reset at pixel 50 with a read in flight
    start_frame;
    collect(50, 1'b0, -1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("midrst_valid", 32'(pix_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_adrs", 32'(picture_radrs), 32'd1792);
    chk("midrst_done", 32'(frame_done), 32'd0);
    step;
    chk("midrst_discard", 32'(pix_valid), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    // back-to-back: request in the frame_done cycle ignored, next cycle accepted
    start_frame;
    collect(256, 1'b0, -1);
    end_frame(1'b1);
    start_frame;
    collect(256, 1'b0, -1);
    end_frame(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
